// File: rtl/encoder8_to_3_serial_pkg.sv
// Shared constants, FSM state type and popcount helper for the serial 8-to-3 encoder.
// ROUND_ROBIN_EN (optional macro) selects rotating priority in the top module.
package enc_pkg;
    localparam int N = 8;
    localparam int W = $clog2(N);

    typedef enum logic {IDLE, BUSY} state_t;

    function automatic logic [3:0] popcount(input logic [N-1:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < N; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction
endpackage

// File: rtl/encoder8_to_3_serial_if.sv
// Request/grant bus of the serial encoder: request loading, grant handshake and status.
interface encoder8_to_3_serial_if;
    import enc_pkg::*;

    logic         en;
    logic [N-1:0] in;
    logic         in_valid;
    logic [W-1:0] out;
    logic         out_valid;
    logic         out_ready;
    logic [3:0]   pend_cnt;
    logic         zero_req;

    modport master (
        output en, in, in_valid, out_ready,
        input  out, out_valid, pend_cnt, zero_req
    );

    modport slave (
        input  en, in, in_valid, out_ready,
        output out, out_valid, pend_cnt, zero_req
    );
endinterface

// File: rtl/encoder8_to_3_serial_prio_pick.sv
// Combinational priority picker: first set bit of vec searching downward from ptr, with wrap.
module prio_pick
    import enc_pkg::*;
(
    input  logic [N-1:0] vec,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         any
);
    logic [W-1:0] cand;

    always_comb begin
        idx  = '0;
        any  = 1'b0;
        cand = ptr;
        for (int i = 0; i < N; i++) begin
            cand = ptr - W'(i);
            if (!any && vec[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/encoder8_to_3_serial.sv
// Serial 8-to-3 priority encoder: sticky pending register, one grant per handshake.
// ROUND_ROBIN_EN defined: rotating priority from rr_ptr; undefined: bit 7 highest.
//   state | meaning
//   IDLE  | nothing pending, out_valid low
//   BUSY  | grant presented on out, waiting for out_ready
module encoder8_to_3_serial
    import enc_pkg::*;
(
    input logic                   clk,
    input logic                   rst,
    encoder8_to_3_serial_if.slave bus
);
    state_t       state, state_nxt;
    logic [N-1:0] pending, pend_nxt, clr, load;
    logic [W-1:0] out_r, out_nxt, ptr_nxt, pick_idx;
    logic [3:0]   cnt_r;
    logic         zero_r, pick_any, hs;

`ifdef ROUND_ROBIN_EN
    logic [W-1:0] rr_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '1;
        end else if (hs) begin
            rr_ptr <= out_r - W'(1);
        end
    end

    // The pick for the next grant must already see the pointer moved past this grant.
    assign ptr_nxt = hs ? out_r - W'(1) : rr_ptr;
`else
    assign ptr_nxt = '1;
`endif

    prio_pick u_pick (
        .vec (pend_nxt),
        .ptr (ptr_nxt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        hs        = bus.en & (state == BUSY) & bus.out_ready;
        clr       = hs ? (N'(1) << out_r) : '0;
        load      = bus.in_valid ? bus.in : '0;
        pend_nxt  = (pending & ~clr) | load;
        state_nxt = (pend_nxt != '0) ? BUSY : IDLE;
        out_nxt   = out_r;
        // A presented grant is held until accepted; new loads cannot pre-empt it.
        if (((state != BUSY) || hs) && pick_any) begin
            out_nxt = pick_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pending <= '0;
            out_r   <= '0;
            cnt_r   <= '0;
            zero_r  <= 1'b0;
        end else begin
            zero_r <= bus.en & bus.in_valid & (bus.in == '0);
            if (bus.en) begin
                state   <= state_nxt;
                pending <= pend_nxt;
                out_r   <= out_nxt;
                cnt_r   <= popcount(pend_nxt);
            end
        end
    end

    assign bus.out       = out_r;
    assign bus.out_valid = (state == BUSY) & bus.en;
    assign bus.pend_cnt  = cnt_r;
    assign bus.zero_req  = zero_r;
endmodule

// File: tb/tb_encoder8_to_3_serial.sv
// Self-checking bench for encoder8_to_3_serial: vector table, directed corners, random vs model.
module tb_encoder8_to_3_serial;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    encoder8_to_3_serial_if bus ();

    encoder8_to_3_serial dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: set of pending request bits plus the presented grant.
    int m_pend [8];
    int m_out  = 0;
    int m_val  = 0;
    int m_rr   = 7;
    int m_cnt  = 0;
    int m_zero = 0;

    typedef struct {
        logic       r, e;
        logic [7:0] d;
        logic       iv, rdy;
        logic       ev;
        logic [2:0] eo;
        logic       co;
        logic [3:0] ec;
        logic       ez;
    } vec_t;

    vec_t tbl [$];

    task automatic chk(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int pick_first();
        int k;
        for (int j = 0; j < 8; j++) begin
`ifdef ROUND_ROBIN_EN
            k = (m_rr - j + 8) % 8;
`else
            k = 7 - j;
`endif
            if (m_pend[k] != 0) return k;
        end
        return -1;
    endfunction

    task automatic model_step(input logic r, e, input logic [7:0] d, input logic iv, rdy);
        int granted, k;
        if (r) begin
            foreach (m_pend[i]) m_pend[i] = 0;
            m_out = 0; m_val = 0; m_rr = 7; m_cnt = 0;
        end else if (e) begin
            granted = 0;
            if (m_val != 0 && rdy) begin
                m_pend[m_out] = 0;
                granted = 1;
`ifdef ROUND_ROBIN_EN
                m_rr = (m_out + 7) % 8;
`endif
            end
            if (iv) for (int b = 0; b < 8; b++) if (d[b]) m_pend[b] = 1;
            if (m_val == 0 || granted != 0) begin
                k = pick_first();
                if (k >= 0) m_out = k;
            end
            m_cnt = 0;
            foreach (m_pend[i]) m_cnt += m_pend[i];
            m_val = (m_cnt != 0) ? 1 : 0;
        end
        m_zero = (!r && e && iv && d == 8'h00) ? 1 : 0;
    endtask

    // One clock: drive inputs, clock, advance the model, compare DUT to model.
    task automatic cyc(input logic r, e, input logic [7:0] d, input logic iv, rdy);
        rst = r; bus.en = e; bus.in = d; bus.in_valid = iv; bus.out_ready = rdy;
        @(posedge clk);
        model_step(r, e, d, iv, rdy);
        #1;
        chk("model out_valid", int'(bus.out_valid), (m_val != 0 && e) ? 1 : 0);
        if (m_val != 0 || r) chk("model out", int'(bus.out), m_out);
        chk("model pend_cnt", int'(bus.pend_cnt), m_cnt);
        chk("model zero_req", int'(bus.zero_req), m_zero);
    endtask

    function automatic vec_t mk(logic r, e, logic [7:0] d, logic iv, rdy,
                                logic ev, logic [2:0] eo, logic co, logic [3:0] ec, logic ez);
        vec_t v;
        v.r = r; v.e = e; v.d = d; v.iv = iv; v.rdy = rdy;
        v.ev = ev; v.eo = eo; v.co = co; v.ec = ec; v.ez = ez;
        return v;
    endfunction

    initial begin
        logic [7:0] dec;
        logic [2:0] exp6 [4];
        bus.en = 1'b1; bus.in = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;

        // reset state
        tbl.push_back(mk(1, 1, 8'h00, 0, 0, 0, 0, 1, 0, 0));
        // 1010_0101 burst: 7,5,2,0 then idle
        tbl.push_back(mk(0, 1, 8'hA5, 1, 1, 1, 7, 1, 4, 0));
        tbl.push_back(mk(0, 1, 8'h00, 0, 1, 1, 5, 1, 3, 0));
        tbl.push_back(mk(0, 1, 8'h00, 0, 1, 1, 2, 1, 2, 0));
        tbl.push_back(mk(0, 1, 8'h00, 0, 1, 1, 0, 1, 1, 0));
        tbl.push_back(mk(0, 1, 8'h00, 0, 1, 0, 0, 0, 0, 0));
        // stall on 5 while 0x80 loads, no pre-emption
        tbl.push_back(mk(0, 1, 8'h20, 1, 0, 1, 5, 1, 1, 0));
        tbl.push_back(mk(0, 1, 8'h80, 1, 0, 1, 5, 1, 2, 0));
        tbl.push_back(mk(0, 1, 8'h00, 0, 0, 1, 5, 1, 2, 0));
        tbl.push_back(mk(0, 1, 8'h00, 0, 0, 1, 5, 1, 2, 0));
        tbl.push_back(mk(0, 1, 8'h00, 0, 1, 1, 7, 1, 1, 0));
        tbl.push_back(mk(0, 1, 8'h00, 0, 1, 0, 0, 0, 0, 0));
        // same-bit clear and set: 3 stays pending
        tbl.push_back(mk(0, 1, 8'h08, 1, 0, 1, 3, 1, 1, 0));
        tbl.push_back(mk(0, 1, 8'h08, 1, 1, 1, 3, 1, 1, 0));
        tbl.push_back(mk(0, 1, 8'h00, 0, 1, 0, 0, 0, 0, 0));
        // en low mid-burst, then reset mid-burst with a handshake pending
        tbl.push_back(mk(0, 1, 8'hE0, 1, 1, 1, 7, 1, 3, 0));
        tbl.push_back(mk(0, 1, 8'h00, 0, 1, 1, 6, 1, 2, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 0, 6, 1, 2, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 0, 6, 1, 2, 0));
        tbl.push_back(mk(0, 1, 8'h00, 0, 0, 1, 6, 1, 2, 0));
        tbl.push_back(mk(0, 1, 8'h00, 0, 1, 1, 5, 1, 1, 0));
        tbl.push_back(mk(1, 1, 8'h00, 0, 1, 0, 0, 1, 0, 0));
        // zero request pulse
        tbl.push_back(mk(0, 1, 8'h00, 1, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 8'h00, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 1, 0, 0, 0, 0, 0));

        cyc(1, 1, 8'h00, 0, 0);
        foreach (tbl[i]) begin
            cyc(tbl[i].r, tbl[i].e, tbl[i].d, tbl[i].iv, tbl[i].rdy);
            chk($sformatf("tbl[%0d] out_valid", i), int'(bus.out_valid), int'(tbl[i].ev));
            if (tbl[i].co) chk($sformatf("tbl[%0d] out", i), int'(bus.out), int'(tbl[i].eo));
            chk($sformatf("tbl[%0d] pend_cnt", i), int'(bus.pend_cnt), int'(tbl[i].ec));
            chk($sformatf("tbl[%0d] zero_req", i), int'(bus.zero_req), int'(tbl[i].ez));
        end

        // one-hot sweep through a 3-to-8 decoder, one grant per load
        cyc(1, 1, 8'h00, 0, 0);
        for (int k = 0; k < 8; k++) begin
            cyc(0, 1, 8'(1 << k), 1, 1);
            dec = 8'(1 << bus.out);
            chk($sformatf("sweep%0d valid", k), int'(bus.out_valid), 1);
            chk($sformatf("sweep%0d decoded", k), int'(dec), 1 << k);
            cyc(0, 1, 8'h00, 0, 1);
            chk($sformatf("sweep%0d single", k), int'(bus.out_valid), 0);
        end

        // 0x81 reloaded every cycle: rotating vs fixed priority
`ifdef ROUND_ROBIN_EN
        exp6[0] = 3'd7; exp6[1] = 3'd0; exp6[2] = 3'd7; exp6[3] = 3'd0;
`else
        exp6[0] = 3'd7; exp6[1] = 3'd7; exp6[2] = 3'd7; exp6[3] = 3'd7;
`endif
        cyc(1, 1, 8'h00, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 8'h81, 1, 1);
            chk($sformatf("prio81 grant%0d", i), int'(bus.out), int'(exp6[i]));
            chk($sformatf("prio81 cnt%0d", i), int'(bus.pend_cnt), 2);
        end

        // random traffic against the model
        cyc(1, 1, 8'h00, 0, 0);
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 99) < 2),
                ($urandom_range(0, 9) != 0),
                ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom),
                ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 3) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
